// File: rtl/uart_mem_arbiter.sv
// Round-robin arbiter sharing one UART byte link between the PicoRV instruction and data ports.
// Each grant sends one command packet, collects the host response and completes that port's handshake.
module uart_mem_arbiter #(
    parameter int unsigned TimeoutCycles = 1200000
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        i_valid_i,
    input  logic [31:0] i_addr_i,
    output logic        i_ready_o,
    output logic [31:0] i_rdata_o,
    input  logic        d_valid_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_wstrb_i,
    output logic        d_ready_o,
    output logic [31:0] d_rdata_o,
    output logic        err_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        busy_o,
    output logic        rx_drop_o
);
    // state | meaning
    // IDLE  | no transaction; arbitrate pending requests
    // SEND  | stream command packet to the transmitter
    // RECV  | collect response bytes, run the inter-byte timeout
    // DONE  | one-cycle completion pulse to the granted port
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_RECV = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam bit          TOUT_EN   = (TimeoutCycles != 0);
    localparam logic [31:0] TOUT_LAST = 32'(TimeoutCycles - 1);

    logic [1:0]  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        write_q, write_d;
    logic [3:0]  idx_q, idx_d;
    logic [1:0]  rx_cnt_q, rx_cnt_d;
    logic [31:0] rx_buf_q, rx_buf_d;
    logic [31:0] tout_q, tout_d;
    logic        err_q, err_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        rx_drop_q, rx_drop_d;

    logic        win;
    logic [3:0]  last_idx;
    logic [31:0] rx_word;
    logic [7:0]  tx_byte;

    assign last_idx = write_q ? 4'd8 : 4'd4;
    // response bytes arrive little-endian, so shift each new byte in from the top
    assign rx_word  = {rx_data_i, rx_buf_q[31:8]};

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        write_d      = write_q;
        idx_d        = idx_q;
        rx_cnt_d     = rx_cnt_q;
        rx_buf_d     = rx_buf_q;
        tout_d       = tout_q;
        err_d        = err_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        rx_drop_d    = rx_valid_i && (state_q != ST_RECV);
        win          = PORT_I;

        case (state_q)
            ST_IDLE: begin
                if (i_valid_i || d_valid_i) begin
                    if (i_valid_i && d_valid_i) win = (last_grant_q == PORT_D) ? PORT_I : PORT_D;
                    else                        win = d_valid_i ? PORT_D : PORT_I;
                    grant_d      = win;
                    last_grant_d = win;
                    addr_d       = win ? d_addr_i : i_addr_i;
                    wdata_d      = win ? d_wdata_i : 32'h0;
                    wstrb_d      = win ? d_wstrb_i : 4'h0;
                    write_d      = win && (d_wstrb_i != 4'h0);
                    idx_d        = 4'd0;
                    err_d        = 1'b0;
                    state_d      = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_ready_i) begin
                    if (idx_q == last_idx) begin
                        state_d  = ST_RECV;
                        rx_cnt_d = 2'd0;
                        tout_d   = 32'd0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_RECV: begin
                if (rx_valid_i) begin
                    rx_buf_d = rx_word;
                    rx_cnt_d = rx_cnt_q + 2'd1;
                    tout_d   = 32'd0;
                    if (write_q || rx_cnt_q == 2'd3) begin
                        state_d = ST_DONE;
                        err_d   = 1'b0;
                        if (grant_q == PORT_D) d_rdata_d = write_q ? 32'h0 : rx_word;
                        else                   i_rdata_d = rx_word;
                    end
                end else if (TOUT_EN && tout_q == TOUT_LAST) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    if (grant_q == PORT_D) d_rdata_d = 32'h0;
                    else                   i_rdata_d = 32'h0;
                end else begin
                    tout_d = tout_q + 32'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_D;
            grant_q      <= PORT_I;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            write_q      <= 1'b0;
            idx_q        <= 4'd0;
            rx_cnt_q     <= 2'd0;
            rx_buf_q     <= 32'h0;
            tout_q       <= 32'd0;
            err_q        <= 1'b0;
            i_rdata_q    <= 32'h0;
            d_rdata_q    <= 32'h0;
            rx_drop_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            write_q      <= write_d;
            idx_q        <= idx_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_buf_q     <= rx_buf_d;
            tout_q       <= tout_d;
            err_q        <= err_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            rx_drop_q    <= rx_drop_d;
        end
    end

    always_comb begin
        tx_byte = 8'h00;
        case (idx_q)
            4'd0: tx_byte = {write_q, 3'b000, wstrb_q};
            4'd1: tx_byte = addr_q[7:0];
            4'd2: tx_byte = addr_q[15:8];
            4'd3: tx_byte = addr_q[23:16];
            4'd4: tx_byte = addr_q[31:24];
            4'd5: tx_byte = wdata_q[7:0];
            4'd6: tx_byte = wdata_q[15:8];
            4'd7: tx_byte = wdata_q[23:16];
            4'd8: tx_byte = wdata_q[31:24];
            default: tx_byte = 8'h00;
        endcase
    end

    // decoded straight from state_q so an async reset drops tx_valid_o at once
    assign tx_valid_o = (state_q == ST_SEND);
    assign tx_data_o  = tx_valid_o ? tx_byte : 8'h00;
    assign busy_o     = (state_q != ST_IDLE);
    assign i_ready_o  = (state_q == ST_DONE) && (grant_q == PORT_I);
    assign d_ready_o  = (state_q == ST_DONE) && (grant_q == PORT_D);
    assign err_o      = (state_q == ST_DONE) && err_q;
    assign i_rdata_o  = i_rdata_q;
    assign d_rdata_o  = d_rdata_q;
    assign rx_drop_o  = rx_drop_q;
endmodule

// File: tb/tb_uart_mem_arbiter.sv
// Bench for uart_mem_arbiter: table vectors, directed corner sequences and random
// traffic checked against a packet/arbitration reference model.
module tb_uart_mem_arbiter;
    localparam int TOUT = 50;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        i_valid_i, d_valid_i, tx_ready_i, rx_valid_i;
    logic [31:0] i_addr_i, d_addr_i, d_wdata_i;
    logic [3:0]  d_wstrb_i;
    logic [7:0]  rx_data_i;
    logic        i_ready_o, d_ready_o, err_o, tx_valid_o, busy_o, rx_drop_o;
    logic [31:0] i_rdata_o, d_rdata_o;
    logic [7:0]  tx_data_o;

    uart_mem_arbiter #(.TimeoutCycles(TOUT)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .i_valid_i(i_valid_i), .i_addr_i(i_addr_i), .i_ready_o(i_ready_o), .i_rdata_o(i_rdata_o),
        .d_valid_i(d_valid_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_wstrb_i(d_wstrb_i),
        .d_ready_o(d_ready_o), .d_rdata_o(d_rdata_o), .err_o(err_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .busy_o(busy_o), .rx_drop_o(rx_drop_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    bit          mdl_last;      // 1 = data port won the last grant
    logic [31:0] mdl_i_rdata, mdl_d_rdata;

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] resp;
        logic [31:0] exp_rdata;
        int          exp_len;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pick(input bit iv, input bit dv);
        if (iv && dv) return !mdl_last;
        return dv;
    endfunction

    // Serve one transaction for the port the model says wins; called at a negedge.
    task automatic serve(input bit exp_d, input logic [31:0] resp, input bit rnd,
                         input int stall_byte, input int stall_len, input int nsend_in,
                         input bit exp_err, output int got_len, output logic [31:0] got_rdata);
        logic [7:0]  exp_pkt[$];
        logic [7:0]  prev_data;
        logic [31:0] a, wd, exp_rd;
        logic [3:0]  ws;
        bit          wr, prev_stall;
        int          stalled, budget, nsend, waited;
        a  = exp_d ? d_addr_i : i_addr_i;
        wd = d_wdata_i;
        ws = exp_d ? d_wstrb_i : 4'h0;
        wr = (ws != 4'h0);
        exp_pkt = {};
        exp_pkt.push_back({wr, 3'b000, ws});
        for (int k = 0; k < 4; k++) exp_pkt.push_back(a[8*k +: 8]);
        if (wr) for (int k = 0; k < 4; k++) exp_pkt.push_back(wd[8*k +: 8]);
        nsend = (nsend_in != 0) ? nsend_in : (wr ? 1 : 4);

        got_len = 0; prev_stall = 0; stalled = 0; budget = 0; prev_data = 8'h00;
        while (got_len < exp_pkt.size() && budget < 400) begin
            @(negedge clk_i);
            budget++;
            if (prev_stall) begin
                check("tx_hold_valid", tx_valid_o, 1'b1);
                check("tx_hold_data", tx_data_o, prev_data);
            end
            if (tx_valid_o) begin
                if (got_len == stall_byte && stalled < stall_len) begin
                    tx_ready_i = 1'b0;
                    stalled++;
                end else begin
                    tx_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                prev_stall = !tx_ready_i;
                prev_data  = tx_data_o;
                if (tx_ready_i) begin
                    check("tx_byte", tx_data_o, exp_pkt[got_len]);
                    got_len++;
                end
            end else begin
                tx_ready_i = 1'($urandom_range(0, 1));
                prev_stall = 1'b0;
            end
        end
        if (budget >= 400) check("tx_packet_timeout", got_len, exp_pkt.size());

        @(negedge clk_i);
        tx_ready_i = 1'b0;
        check("recv_tx_idle", tx_valid_o, 1'b0);
        check("recv_busy", busy_o, 1'b1);

        for (int k = 0; k < nsend; k++) begin
            if (k > 0 && rnd) repeat ($urandom_range(0, 3)) @(negedge clk_i);
            rx_data_i  = resp[8*k +: 8];
            rx_valid_i = 1'b1;
            @(negedge clk_i);
            rx_valid_i = 1'b0;
        end
        waited = 1;
        while (!(i_ready_o || d_ready_o) && waited < TOUT + 20) begin
            @(negedge clk_i);
            waited++;
        end
        check("ready_latency", waited, exp_err ? TOUT + 1 : 1);

        exp_rd = (exp_err || wr) ? 32'h0 : resp;
        check("ready_own", exp_d ? d_ready_o : i_ready_o, 1'b1);
        check("ready_other", exp_d ? i_ready_o : d_ready_o, 1'b0);
        check("err", err_o, exp_err);
        got_rdata = exp_d ? d_rdata_o : i_rdata_o;
        check("rdata_own", got_rdata, exp_rd);
        check("rdata_other", exp_d ? i_rdata_o : d_rdata_o, exp_d ? mdl_i_rdata : mdl_d_rdata);
        if (exp_d) begin mdl_d_rdata = exp_rd; d_valid_i = 1'b0; end
        else       begin mdl_i_rdata = exp_rd; i_valid_i = 1'b0; end
        mdl_last = exp_d;

        @(negedge clk_i);
        check("idle_gap_busy", busy_o, 1'b0);
        check("ready_pulse_width", exp_d ? d_ready_o : i_ready_o, 1'b0);
    endtask

    initial begin
        int          len, guard, n;
        logic [31:0] rd;
        bit          w;

        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h0000_0013, 32'h0000_0013, 5};
        vecs[1] = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0000_00A5, 32'h0,         9};
        vecs[2] = '{1'b1, 32'h2000_0004, 32'h1111_1111, 4'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 5};
        vecs[3] = '{1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 4'h1, 32'h0000_0000, 32'h0,         9};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'h0,         4'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5};

        i_valid_i = 0; d_valid_i = 0; tx_ready_i = 0; rx_valid_i = 0;
        i_addr_i = 0; d_addr_i = 0; d_wdata_i = 0; d_wstrb_i = 0; rx_data_i = 0;
        mdl_last = 1'b1; mdl_i_rdata = 0; mdl_d_rdata = 0;
        reset_ni = 1'b1;
        #2 reset_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_busy", busy_o, 1'b0);
        check("rst_tx_valid", tx_valid_o, 1'b0);
        check("rst_tx_data", tx_data_o, 8'h00);
        check("rst_readies", {i_ready_o, d_ready_o, err_o, rx_drop_o}, 4'h0);
        check("rst_i_rdata", i_rdata_o, 32'h0);
        check("rst_d_rdata", d_rdata_o, 32'h0);
        reset_ni = 1'b1;
        @(negedge clk_i);

        // contention out of reset: instr first; instr re-requests at once -> data wins
        i_addr_i = 32'h80; d_addr_i = 32'h90; d_wstrb_i = 4'h0;
        i_valid_i = 1'b1; d_valid_i = 1'b1;
        w = pick(i_valid_i, d_valid_i);
        check("arb_first_is_instr", w, 1'b0);
        serve(w, 32'h0A0B0C0D, 0, -1, 0, 0, 0, len, rd);
        i_addr_i = 32'h84; i_valid_i = 1'b1;
        w = pick(i_valid_i, d_valid_i);
        serve(w, 32'h11223344, 0, -1, 0, 0, 0, len, rd);
        serve(pick(i_valid_i, d_valid_i), 32'h55667788, 0, -1, 0, 0, 0, len, rd);

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].is_d) begin
                d_addr_i = vecs[v].addr; d_wdata_i = vecs[v].wdata;
                d_wstrb_i = vecs[v].wstrb; d_valid_i = 1'b1;
            end else begin
                i_addr_i = vecs[v].addr; i_valid_i = 1'b1;
            end
            serve(pick(i_valid_i, d_valid_i), vecs[v].resp, 0, -1, 0, 0, 0, len, rd);
            check("vec_len", len, vecs[v].exp_len);
            check("vec_rdata", rd, vecs[v].exp_rdata);
        end

        // transmitter stalls 7 cycles on byte 2 of a write
        d_addr_i = 32'h0000_0200; d_wdata_i = 32'h0102_0304; d_wstrb_i = 4'h6; d_valid_i = 1'b1;
        serve(1'b1, 32'h0, 0, 2, 7, 0, 0, len, rd);
        check("stall_len", len, 9);

        // host sends 2 of 4 read bytes then goes silent
        i_addr_i = 32'h0000_0020; i_valid_i = 1'b1;
        serve(1'b0, 32'h0000_BBAA, 0, -1, 0, 2, 1, len, rd);
        i_addr_i = 32'h0000_0024; i_valid_i = 1'b1;
        serve(1'b0, 32'h8765_4321, 0, -1, 0, 0, 0, len, rd);
        check("post_timeout_rdata", rd, 32'h8765_4321);

        for (int it = 0; it < 24; it++) begin
            if (!i_valid_i && $urandom_range(0, 1) == 1) begin
                i_addr_i = $urandom; i_valid_i = 1'b1;
            end
            if (!d_valid_i && $urandom_range(0, 1) == 1) begin
                d_addr_i = $urandom; d_wdata_i = $urandom;
                d_wstrb_i = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                d_valid_i = 1'b1;
            end
            if (!i_valid_i && !d_valid_i) begin
                i_addr_i = $urandom; i_valid_i = 1'b1;
            end
            serve(pick(i_valid_i, d_valid_i), $urandom, 1, -1, 0, 0, 0, len, rd);
        end
        guard = 0;
        while ((i_valid_i || d_valid_i) && guard < 2) begin
            serve(pick(i_valid_i, d_valid_i), $urandom, 1, -1, 0, 0, 0, len, rd);
            guard++;
        end

        // reset during SEND: tx_valid_o must fall without waiting for a clock
        d_addr_i = 32'h300; d_wdata_i = 32'hA5A5_5A5A; d_wstrb_i = 4'hF; d_valid_i = 1'b1;
        tx_ready_i = 1'b0;
        guard = 0;
        while (!tx_valid_o && guard < 10) begin @(negedge clk_i); guard++; end
        check("send_reached", tx_valid_o, 1'b1);
        #2 reset_ni = 1'b0;
        #1;
        check("async_tx_valid", tx_valid_o, 1'b0);
        check("async_busy", busy_o, 1'b0);
        d_valid_i = 1'b0;
        mdl_last = 1'b1; mdl_i_rdata = 0; mdl_d_rdata = 0;
        @(negedge clk_i);
        reset_ni = 1'b1;

        // reset during RECV, then a stray byte, then a clean read
        @(negedge clk_i);
        i_addr_i = 32'h40; i_valid_i = 1'b1;
        n = 0; guard = 0;
        while (n < 5 && guard < 40) begin
            @(negedge clk_i);
            guard++;
            tx_ready_i = tx_valid_o;
            if (tx_valid_o) n++;
        end
        @(negedge clk_i);
        tx_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rx_data_i = 8'h77; rx_valid_i = 1'b1;
            @(negedge clk_i);
            rx_valid_i = 1'b0;
        end
        check("recv_before_reset", {busy_o, tx_valid_o}, 2'b10);
        reset_ni = 1'b0; i_valid_i = 1'b0;
        #1;
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_flags", {i_ready_o, d_ready_o, err_o, tx_valid_o}, 4'h0);
        check("mid_rst_i_rdata", i_rdata_o, 32'h0);
        check("mid_rst_d_rdata", d_rdata_o, 32'h0);
        mdl_last = 1'b1; mdl_i_rdata = 0; mdl_d_rdata = 0;
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);
        rx_data_i = 8'h5A; rx_valid_i = 1'b1;
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        check("stray_drop", rx_drop_o, 1'b1);
        check("stray_idle_ready", {i_ready_o, d_ready_o}, 2'b00);
        @(negedge clk_i);
        check("stray_drop_pulse", rx_drop_o, 1'b0);
        i_addr_i = 32'h44; i_valid_i = 1'b1;
        serve(1'b0, 32'h0102_0304, 0, -1, 0, 0, 0, len, rd);
        check("recovery_rdata", rd, 32'h0102_0304);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
